// File: rtl/sn74ls195a_deserializer.sv
// Serial-to-parallel receiver for a word stream clocked out of an SN74LS195A.
// PE mirrors the transmitter's load/shift mode; a low PE marks a frame boundary.
module sn74ls195a_deserializer #(
  parameter int unsigned WIDTH = 4
) (
  input  logic                   CP,
  input  logic                   MR,
  input  logic                   PE,
  input  logic                   D,
  output logic [WIDTH-1:0]       Q,
  output logic [WIDTH-1:0]       WORD,
  output logic                   VALID,
  output logic                   ABORT,
  output logic [$clog2(WIDTH):0] COUNT
);

  localparam int unsigned CW = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] COUNT_LAST = CW'(WIDTH - 1);

  if (WIDTH < 2 || WIDTH > 16) begin : g_width_check
    $error("sn74ls195a_deserializer: WIDTH must be in 2..16");
  end

  typedef enum logic {
    IDLE,
    SYNCED
  } state_t;

  state_t          state_q, state_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic [WIDTH-1:0] word_q, word_d;
  logic             valid_q, valid_d;
  logic             abort_q, abort_d;
  logic [CW-1:0]    count_q, count_d;
  logic [WIDTH-1:0] shifted;

  always_ff @(posedge CP or negedge MR) begin
    if (!MR) begin
      state_q <= IDLE;
      q_q     <= '0;
      word_q  <= '0;
      valid_q <= 1'b0;
      abort_q <= 1'b0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      q_q     <= q_d;
      word_q  <= word_d;
      valid_q <= valid_d;
      abort_q <= abort_d;
      count_q <= count_d;
    end
  end

  always_comb begin
    state_d = state_q;
    q_d     = q_q;
    word_d  = word_q;
    valid_d = 1'b0;
    abort_d = 1'b0;
    count_d = count_q;
    shifted = {q_q[WIDTH-2:0], D};

    unique case (state_q)
      IDLE: begin
        q_d     = '0;
        count_d = '0;
        if (!PE) state_d = SYNCED;
      end
      SYNCED: begin
        if (PE) begin
          q_d = shifted;
          // Completing edge publishes the word and wraps so the next word needs no re-sync.
          if (count_q == COUNT_LAST) begin
            word_d  = shifted;
            valid_d = 1'b1;
            count_d = '0;
          end else begin
            count_d = count_q + 1'b1;
          end
        end else if (count_q != '0) begin
          q_d     = '0;
          count_d = '0;
          abort_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign Q     = q_q;
  assign WORD  = word_q;
  assign VALID = valid_q;
  assign ABORT = abort_q;
  assign COUNT = count_q;

endmodule

// File: tb/tb_sn74ls195a_deserializer.sv
// Scoreboard bench: stimulus predicts strobes from a bit-history model; a monitor
// pops and compares whenever VALID or ABORT is presented.
module tb_sn74ls195a_deserializer;
  localparam int unsigned W = 4;

  logic cp = 1'b0;
  logic mr, pe, d, d_drv, tx_mode;
  logic [W-1:0] q, word;
  logic valid, abort;
  logic [$clog2(W):0] count;

  logic [3:0] tx_q, tx_p;
  logic tx_j, tx_kb;

  typedef struct {
    bit           is_abort;
    logic [W-1:0] word;
  } ev_t;

  ev_t exp_q[$];
  bit  hist[$];
  int unsigned m_cnt;
  bit  m_synced;
  logic [W-1:0] m_word;
  int errors = 0;
  int checks = 0;

  sn74ls195a_deserializer #(.WIDTH(W)) dut (
    .CP(cp), .MR(mr), .PE(pe), .D(d),
    .Q(q), .WORD(word), .VALID(valid), .ABORT(abort), .COUNT(count)
  );

  always #5 cp = ~cp;

  assign d = tx_mode ? tx_q[3] : d_drv;

  // Behavioural SN74LS195A transmitter: parallel load on PE=0, else shift toward Q3 with J/K-bar into Q0.
  always @(posedge cp or negedge mr) begin
    if (!mr) tx_q <= '0;
    else if (!pe) tx_q <= tx_p;
    else tx_q <= {tx_q[2:0], (tx_j & ~tx_q[0]) | (tx_kb & tx_q[0])};
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Live register value = the most recent W received bits since the last clear, MSB first.
  function automatic logic [W-1:0] model_q();
    int unsigned v = 0;
    foreach (hist[i]) v = (v * 2 + int'(hist[i])) % (1 << W);
    return W'(v);
  endfunction

  task automatic step(input bit p, input bit b);
    pe    = p;
    d_drv = b;
    if (!m_synced) begin
      if (!p) m_synced = 1'b1;
    end else if (p) begin
      hist.push_back(b);
      if (hist.size() > W) void'(hist.pop_front());
      m_cnt++;
      if (m_cnt == W) begin
        m_word = model_q();
        exp_q.push_back('{1'b0, m_word});
        m_cnt = 0;
      end
    end else if (m_cnt != 0) begin
      exp_q.push_back('{1'b1, m_word});
      hist.delete();
      m_cnt = 0;
    end
    @(posedge cp);
    #1;
    check("Q", q, model_q());
    check("COUNT", count, m_cnt);
    check("WORD", word, m_word);
    @(negedge cp);
  endtask

  task automatic do_reset();
    #2 mr = 1'b0;
    #1;
    check("rst_Q", q, 0);
    check("rst_WORD", word, 0);
    check("rst_VALID", valid, 0);
    check("rst_ABORT", abort, 0);
    check("rst_COUNT", count, 0);
    m_synced = 1'b0;
    hist.delete();
    m_cnt  = 0;
    m_word = '0;
    #1 mr = 1'b1;
    step(1'b1, 1'b1);
  endtask

  always @(negedge cp) begin
    ev_t e;
    if (valid || abort) begin
      check("strobe_exclusive", valid & abort, 0);
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_strobe: valid=%b abort=%b but none expected at %0t", valid, abort, $time);
      end else begin
        e = exp_q.pop_front();
        check("strobe_kind_abort", abort, e.is_abort);
        check("strobe_word", word, e.word);
      end
    end
  end

  initial begin
    logic [7:0] stream;
    mr = 1'b0; pe = 1'b1; d_drv = 1'b0; tx_mode = 1'b0;
    tx_p = '0; tx_j = 1'b0; tx_kb = 1'b1;
    m_synced = 1'b0; m_cnt = 0; m_word = '0;

    #3;
    check("init_Q", q, 0);
    check("init_WORD", word, 0);
    check("init_VALID", valid, 0);
    check("init_ABORT", abort, 0);
    check("init_COUNT", count, 0);
    @(negedge cp);
    mr = 1'b1;

    // Data without a prior sync is ignored.
    repeat (6) step(1'b1, 1'b1);

    // Single word after one sync.
    step(1'b0, 1'b0);
    step(1'b1, 1'b1); step(1'b1, 1'b0); step(1'b1, 1'b1); step(1'b1, 1'b0);

    // Back-to-back words without re-sync.
    stream = 8'b1010_0110;
    for (int i = 7; i >= 0; i--) step(1'b1, stream[i]);

    // Mid-word sync aborts; a sync at a word boundary is silent.
    step(1'b1, 1'b1); step(1'b1, 1'b1); step(1'b0, 1'b1);
    step(1'b0, 1'b1);

    // Real transmitter: fixed 1010 frame, then random frames.
    tx_mode = 1'b1;
    tx_p = 4'b1010;
    step(1'b0, 1'b0);
    for (int i = 3; i >= 0; i--) step(1'b1, tx_p[i]);
    repeat (3) begin
      tx_p = 4'($urandom);
      step(1'b0, 1'b0);
      for (int i = 3; i >= 0; i--) step(1'b1, tx_p[i]);
    end
    tx_mode = 1'b0;

    // Mid-word reset: no abort, then a fresh sync is required.
    step(1'b0, 1'b0); step(1'b1, 1'b1); step(1'b1, 1'b0);
    do_reset();
    step(1'b1, 1'b1); step(1'b1, 1'b0);
    step(1'b0, 1'b0);
    step(1'b1, 1'b0); step(1'b1, 1'b1); step(1'b1, 1'b1); step(1'b1, 1'b1);

    // Random traffic with sparse syncs and occasional resets.
    repeat (400) begin
      if ($urandom_range(0, 49) == 0) do_reset();
      else step($urandom_range(0, 5) != 0, 1'($urandom_range(0, 1)));
    end

    step(1'b1, 1'b0);
    #1;
    check("scoreboard_drained", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/sn74ls195a_deserializer.md
SN74LS195A_DESERIALIZER -- requirements
Module: sn74ls195a_deserializer

Interface
REQ-001 Parameter: WIDTH, 4, word length in bits; legal range 2..16.
REQ-002 Port: CP  input  1  rising-edge clock, shared with the transmitting SN74LS195A.
REQ-003 Port: MR  input  1  reset; asynchronous, active-low.
REQ-004 Port: PE  input  1  transmitter mode mirror; 0 = transmitter loading (frame sync), 1 = transmitter shifting.
REQ-005 Port: D  input  1  serial data, driven from the transmitter's Q3 output.
REQ-006 Port: Q  output  WIDTH  live receive shift register contents.
REQ-007 Port: WORD  output  WIDTH  last completed word, held until the next completion.
REQ-008 Port: VALID  output  1  one-cycle strobe; WORD was updated on this edge.
REQ-009 Port: ABORT  output  1  one-cycle strobe; a partial word was discarded by a mid-word sync.
REQ-010 Port: COUNT  output  ceil(log2(WIDTH))+1  number of bits shifted into the current word.

Function
REQ-011 The block SHALL have two states: IDLE and SYNCED.
REQ-012 In IDLE, the block SHALL ignore D, hold Q and COUNT at 0, and move to SYNCED on the first CP edge with PE=0.
REQ-013 In SYNCED, on a CP edge with PE=1, the block SHALL perform Q <= {Q[WIDTH-2:0], D} and COUNT <= COUNT+1.
- The first received bit is the transmitter's P3 (MSB first).
REQ-014 In SYNCED, on the edge that raises COUNT to WIDTH, the block SHALL:
- load WORD with the new shifted value, {Q[WIDTH-2:0], D};
- assert VALID for exactly that cycle;
- reset COUNT to 0 (wrap), so back-to-back words need no new sync.
REQ-015 In SYNCED, on a CP edge with PE=0 and COUNT=0, the block SHALL hold Q and WORD, keep COUNT at 0, and assert neither strobe.
REQ-016 In SYNCED, on a CP edge with PE=0 and 0<COUNT<WIDTH, the block SHALL:
- clear Q and COUNT to 0;
- assert ABORT for one cycle;
- leave WORD unchanged.
REQ-017 VALID and ABORT SHALL never be asserted in the same cycle.
REQ-018 Both strobes SHALL deassert on the next edge unless re-triggered on that edge.
REQ-019 WORD SHALL change only on a VALID edge.
REQ-020 All outputs SHALL be registered, with no combinational path from D or PE to any output.
REQ-021 A D value on an edge where PE=0 SHALL never enter Q.

Reset
REQ-022 While MR=0, the block SHALL asynchronously force state=IDLE, Q=0, WORD=0, VALID=0, ABORT=0 and COUNT=0, regardless of CP.
REQ-023 MR asserted mid-word SHALL discard the partial word without asserting ABORT.
REQ-024 After MR releases, the block SHALL require a fresh PE=0 sync before accepting data.
REQ-025 MR release SHALL take effect at the first CP edge after MR returns to 1.

Verification
REQ-026 The bench SHALL pulse MR=0 mid-simulation with Q partly filled -> all outputs read 0 immediately, before the next CP edge.
REQ-027 The bench SHALL apply MR=1, PE=1 and D=1 for 6 edges with no prior sync -> Q=0, COUNT=0, VALID never asserted.
REQ-028 The bench SHALL apply PE=0 for 1 edge, then PE=1 with D=1,0,1,0 -> on the 4th shift edge WORD=4'b1010 and VALID=1 for one cycle, then COUNT=0.
REQ-029 The bench SHALL send a continuous stream after one sync, D=1,0,1,0,0,1,1,0 -> WORD=1010 then WORD=0110, with VALID 4 edges apart.
REQ-030 The bench SHALL, after sync, shift D=1,1, then apply PE=0 -> ABORT=1 for one cycle, Q=0, COUNT=0, and WORD keeps its prior value.
REQ-031 The bench SHALL connect the block to an SN74LS195A loaded with P=4'b1010 (PE=0 one edge, then PE=1 with J=0, K=1) -> WORD=4'b1010 after 4 shift edges.
